frame_store: RTL
================

# frame_store

Double-buffered frame buffer and the responder end of the sprite command controller's frame-buffer interface. Accepts per-pixel writes (`x`, `y`, `r`, `g`, `b`, `write`) into the back buffer and a `display` strobe that requests a buffer swap. It holds `busy` high until the swap has taken effect at a frame boundary. In parallel, it continuously streams the front buffer out as a raster pixel stream with a valid/ready handshake, toward the video timing block.

## Interface
- `FB_W`, default 256: frame width in pixels, 1..256.
- `FB_H`, default 256: frame height in pixels, 1..256.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `x`, `y` in 8 each: write coordinates.
- `r`, `g`, `b` in 8 each: write colour.
- `write` in 1: single-cycle write strobe.
- `display` in 1: swap request strobe.
- `busy` out 1: swap (and clear, if configured) in progress.
- `px_valid` out 1: output pixel valid.
- `px_ready` in 1: downstream accepts the pixel.
- `px_r`, `px_g`, `px_b` out 8 each: output colour.
- `px_sof` out 1: pixel is (0,0).
- `px_eol` out 1: pixel is x = FB_W-1.

## Operation
- Two banks of FB_W×FB_H×24-bit storage. `front` bit selects the scanned bank; writes go to `!front`. Linear address = y*FB_W + x, 16 bits.
- Write: accepted when `write`=1, `busy`=0, x<FB_W and y<FB_H. Out-of-range or busy writes are silently dropped.
- Control FSM states: RUN, SWAP_WAIT, CLEAR.
  - RUN: `display`=1 → SWAP_WAIT.
  - SWAP_WAIT: when the last pixel of a frame (x=FB_W-1, y=FB_H-1) handshakes (`px_valid`&`px_ready`), toggle `front` → CLEAR if `FB_CLEAR_ON_SWAP_EN`, else RUN.
  - CLEAR: write 0 to every address of the new back bank, one per cycle, from 0 to FB_W*FB_H-1 → RUN.
- `busy` = (state != RUN).
- `display` outside RUN is ignored; there is no queueing.
- `write` and `display` in the same RUN cycle: the write lands in the old back bank, so it is part of the presented frame.
- Scanout: raster counters sx (0..FB_W-1) and sy (0..FB_H-1) wrap x→y→0 and advance on each read issued. Reads are issued whenever the output skid has room.
- A read issued after the swap edge uses the new `front`. Because the swap occurs at a frame boundary, no frame mixes banks.
- `px_sof` and `px_eol` travel with the data through the pipeline.

## Timing
- Reset values: `busy`=0, `px_valid`=0, `px_sof`=0, `px_eol`=0, `px_r/g/b`=0, `front`=0, state RUN, sx=sy=0. Memory contents are not reset.
- Write latency: data written at the clock edge that samples `write`. Readable by scanout from the next cycle.
- `busy` rises the cycle after `display` is sampled.
- `busy` falls the cycle after the final-pixel handshake (no clear), or the cycle after clear address FB_W*FB_H-1 is written.
- Memory read latency is 1 cycle. First `px_valid`=1 occurs 2 cycles after `rst_n` deasserts.
- With `px_ready` held at 1, throughput is 1 pixel/cycle with no bubbles.
- `px_*` outputs are stable while `px_valid`=1 and `px_ready`=0.
- Reset mid-operation: pending swap is discarded, CLEAR is aborted, scanout restarts at (0,0) on bank 0.

## Configuration
- `FB_CLEAR_ON_SWAP_EN` defined: CLEAR state exists. After each swap, the new back bank is zeroed and `busy` stays high for FB_W*FB_H extra cycles.
- `FB_CLEAR_ON_SWAP_EN` undefined: no CLEAR state. The back bank keeps the stale frame from two swaps ago.

## Structure
- Shared package `fb_pkg`:
  - `fb_state_t` enum {RUN, SWAP_WAIT, CLEAR}.
  - `fb_pixel_t` struct {r, g, b, sof, eol}.
  - Constants `FB_ADDR_W`=16 and `FB_COLOR_W`=8.
- Sub-module `fb_pixel_skid`: 2-entry skid buffer between the memory read data and the `px_*` outputs. Provides the "has room" signal that gates read issue.

## Test plan
- Reset, `px_ready`=1, FB_W=FB_H=4 → `px_valid` at cycle 2. Pixels stream contiguously with `px_sof` on pixel 0 and `px_eol` on pixels 3, 7, 11, 15.
- Write (2,1)=0x112233 to back bank, pulse `display` → `busy` high until the pixel-15 handshake. The next frame shows 0x112233 at pixel index 6.
- Write (5,0) or (0,9) with FB_W=FB_H=4 → dropped. Both banks are unchanged after two swaps.
- Hold `px_ready`=0 for 10 cycles mid-frame → outputs frozen. No pixel is lost or duplicated when ready returns.
- `FB_CLEAR_ON_SWAP_EN` defined: after a swap, `busy` stays high exactly 16 extra cycles. The back bank reads all 0 after the next swap.
- Pulse `display` while `busy`=1, and assert `rst_n`=0 during SWAP_WAIT → the second `display` is ignored. After reset, `front`=0, `busy`=0, and the scan restarts at (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
package fb_pkg;

   localparam int unsigned FB_ADDR_W  = 16;
   localparam int unsigned FB_COLOR_W = 8;

   typedef enum logic [1:0] {RUN, SWAP_WAIT, CLEAR} fb_state_t;

   typedef struct packed {
      logic [FB_COLOR_W-1:0] r;
      logic [FB_COLOR_W-1:0] g;
      logic [FB_COLOR_W-1:0] b;
      logic                  sof;
      logic                  eol;
   } fb_pixel_t;

   // Scan token: the pixel plus the frame-position flags the swap logic needs.
   typedef struct packed {
      fb_pixel_t pix;
      logic      last;
      logic      flip;
   } fb_token_t;

   function automatic logic [FB_ADDR_W-1:0] lin_addr(input logic [7:0] col, input logic [7:0] row,
                                                     input logic [FB_ADDR_W-1:0] width);
      return FB_ADDR_W'(row) * width + FB_ADDR_W'(col);
   endfunction

endpackage

// File: rtl/fb_pixel_skid.sv
// Two-entry skid buffer between frame-buffer read data and the pixel stream outputs.
module fb_pixel_skid
   import fb_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      load,
   input  fb_token_t load_data,
   input  logic      ready,
   output logic      room,
   output logic      valid,
   output fb_token_t head
);

   fb_token_t  spare;
   logic [1:0] count;
   logic       pop;
   logic [2:0] occ_next;

   assign valid    = (count != 2'd0);
   assign pop      = valid & ready;
   // A read issued now arrives on load next cycle, so room looks one cycle ahead.
   assign occ_next = 3'(count) + 3'(load) - 3'(pop);
   assign room     = (occ_next < 3'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         head  <= '0;
         spare <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({load, pop})
            2'b10: begin
               if (count == 2'd0) head <= load_data;
               else               spare <= load_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= spare;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= load_data;
               end else begin
                  head  <= spare;
                  spare <= load_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/frame_store.sv
// Double-buffered frame store with raster scanout; define FB_CLEAR_ON_SWAP_EN
// to zero the new back bank after every swap.
module frame_store
   import fb_pkg::*;
#(
   parameter int unsigned FB_W = 256,
   parameter int unsigned FB_H = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   input  logic       write,
   input  logic       display,
   output logic       busy,
   output logic       px_valid,
   input  logic       px_ready,
   output logic [7:0] px_r,
   output logic [7:0] px_g,
   output logic [7:0] px_b,
   output logic       px_sof,
   output logic       px_eol
);

   localparam int unsigned DEPTH = FB_W * FB_H;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [FB_ADDR_W-1:0] WIDTH = FB_ADDR_W'(FB_W);
   localparam logic [7:0] X_LAST = 8'(FB_W - 1);
   localparam logic [7:0] Y_LAST = 8'(FB_H - 1);

   logic [23:0] bank0 [0:(2**AW)-1];
   logic [23:0] bank1 [0:(2**AW)-1];

   fb_state_t   state;
   logic        front;
   logic        swapped;
   logic [7:0]  sx;
   logic [7:0]  sy;
   logic        rd_valid;
   logic        rd_sof;
   logic        rd_eol;
   logic        rd_last;
   logic        rd_flip;
   logic [23:0] rd_data;
   logic        room;
   logic        scan_last;
   logic        pop;
   logic        last_hs;
   logic        squash;
   logic        swap_done;
   logic        flip_now;
   logic        acc_write;
   logic        wr_en;
   logic        wr_bank;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [23:0] wr_data;
   fb_token_t   load_data;
   fb_token_t   head;
`ifdef FB_CLEAR_ON_SWAP_EN
   localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(DEPTH - 1);
   logic [FB_ADDR_W-1:0] clr_addr;
`endif

   assign scan_last = (sx == X_LAST) && (sy == Y_LAST);
   assign pop       = px_valid & px_ready;
   assign last_hs   = pop && head.last && (state == SWAP_WAIT);
   // Normally the read bank flips when the final pixel is issued, so prefetched
   // next-frame pixels already come from the new bank. If the request arrived
   // after that issue, the prefetch is discarded and the scan rewinds instead.
   assign squash    = last_hs && !head.flip && !swapped;
   assign swap_done = last_hs && (head.flip || !swapped);
   assign flip_now  = room && scan_last && (state == SWAP_WAIT) && !swapped && !squash;

   assign acc_write = rst_n && write && !busy && ({1'b0, x} < 9'(FB_W)) && ({1'b0, y} < 9'(FB_H));
   assign rd_addr   = AW'(lin_addr(sx, sy, WIDTH));

   always_comb begin
      wr_en   = acc_write;
      wr_bank = ~front;
      wr_addr = AW'(lin_addr(x, y, WIDTH));
      wr_data = {r, g, b};
`ifdef FB_CLEAR_ON_SWAP_EN
      if (rst_n && (state == CLEAR)) begin
         wr_en   = 1'b1;
         wr_addr = AW'(clr_addr);
         wr_data = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_bank) bank1[wr_addr] <= wr_data;
         else         bank0[wr_addr] <= wr_data;
      end
      rd_data <= front ? bank1[rd_addr] : bank0[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= RUN;
         busy    <= 1'b0;
         front   <= 1'b0;
         swapped <= 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
         clr_addr <= '0;
`endif
      end else begin
         case (state)
            RUN: begin
               if (display) begin
                  state <= SWAP_WAIT;
                  busy  <= 1'b1;
               end
            end
            SWAP_WAIT: begin
               if (flip_now) begin
                  front   <= ~front;
                  swapped <= 1'b1;
               end
               if (swap_done) begin
                  swapped <= 1'b0;
                  if (squash) front <= ~front;
`ifdef FB_CLEAR_ON_SWAP_EN
                  state    <= CLEAR;
                  clr_addr <= '0;
`else
                  state <= RUN;
                  busy  <= 1'b0;
`endif
               end
            end
`ifdef FB_CLEAR_ON_SWAP_EN
            CLEAR: begin
               clr_addr <= clr_addr + 16'd1;
               if (clr_addr == LAST_ADDR) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end
            end
`endif
            default: begin
               state <= RUN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sx       <= '0;
         sy       <= '0;
         rd_valid <= 1'b0;
         rd_sof   <= 1'b0;
         rd_eol   <= 1'b0;
         rd_last  <= 1'b0;
         rd_flip  <= 1'b0;
      end else if (squash) begin
         sx       <= '0;
         sy       <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= room;
         if (room) begin
            rd_sof  <= (sx == 8'd0) && (sy == 8'd0);
            rd_eol  <= (sx == X_LAST);
            rd_last <= scan_last;
            rd_flip <= flip_now;
            if (sx == X_LAST) begin
               sx <= '0;
               sy <= (sy == Y_LAST) ? 8'd0 : sy + 8'd1;
            end else begin
               sx <= sx + 8'd1;
            end
         end
      end
   end

   always_comb begin
      load_data       = '0;
      load_data.pix.r = rd_data[23:16];
      load_data.pix.g = rd_data[15:8];
      load_data.pix.b = rd_data[7:0];
      load_data.pix.sof = rd_sof;
      load_data.pix.eol = rd_eol;
      load_data.last  = rd_last;
      load_data.flip  = rd_flip;
   end

   fb_pixel_skid u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (squash),
      .load      (rd_valid),
      .load_data (load_data),
      .ready     (px_ready),
      .room      (room),
      .valid     (px_valid),
      .head      (head)
   );

   assign px_r   = head.pix.r;
   assign px_g   = head.pix.g;
   assign px_b   = head.pix.b;
   assign px_sof = head.pix.sof;
   assign px_eol = head.pix.eol;

endmodule
